// File: rtl/vcore_disp_opnd_fetch.sv
// Vector dispatch operand-fetch stage: sequences up to two VRF reads
// through one arbitrated port and presents the assembled payload downstream.

package vcore_pkg;
    localparam int VCORE_OPCODE_W   = 7;
    localparam int VCORE_CSR_VLEN_W = 8;
    localparam int VCORE_VRF_ID_W   = 2;
    localparam int VCORE_VDP_W      = 64;

    localparam logic [VCORE_OPCODE_W-1:0] VCORE_OP_VFLD  = 7'h21;
    localparam logic [VCORE_OPCODE_W-1:0] VCORE_OP_VFSLD = 7'h22;
    localparam logic [VCORE_OPCODE_W-1:0] VCORE_OP_VFST  = 7'h23;

    typedef struct packed {
        logic [1:0] mode;
        logic [3:0] stride;
        logic [1:0] ew;
        logic       signext;
    } vcore_vls_comm_ctrl_info_t;

    typedef struct packed {
        logic [VCORE_OPCODE_W-1:0]   opcode;
        logic [VCORE_CSR_VLEN_W-1:0] vlen;
        logic [2:0]                  rounding;
        logic [4:0]                  vdst0_addr;
        logic [VCORE_VRF_ID_W-1:0]   vdst1_id;
        logic                        vsrc0_vld;
        logic                        vsrc1_vld;
        logic [VCORE_VDP_W-1:0]      vsrc0_data;
        logic [VCORE_VDP_W-1:0]      vsrc1_data;
        vcore_vls_comm_ctrl_info_t   vls_comm_ctrl_info;
    } vcore_i2_i3_ppln_t;
endpackage

module vcore_disp_opnd_fetch
    import vcore_pkg::*;
#(
    parameter int VDP_W      = VCORE_VDP_W,
    parameter int VRF_ADDR_W = 5,
    parameter int RD_LAT     = 1
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       flush,
    input  logic                                       valid_in,
    output logic                                       ready_out,
    input  logic [VCORE_OPCODE_W-1:0]                  opcode_in,
    input  logic [VCORE_CSR_VLEN_W-1:0]                vlen_in,
    input  logic [2:0]                                 rounding_in,
    input  logic [4:0]                                 vdst0_addr_in,
    input  logic [VCORE_VRF_ID_W-1:0]                  vdst1_id_in,
    input  logic                                       vsrc0_vld_in,
    input  logic                                       vsrc1_vld_in,
    input  logic [VRF_ADDR_W-1:0]                      vsrc0_addr_in,
    input  logic [VRF_ADDR_W-1:0]                      vsrc1_addr_in,
    input  logic [$bits(vcore_vls_comm_ctrl_info_t)-1:0] vls_info_in,
    output logic                                       vrf_rd_req,
    output logic [VRF_ADDR_W-1:0]                      vrf_rd_addr,
    input  logic                                       vrf_rd_gnt,
    input  logic [VDP_W-1:0]                           vrf_rd_data,
    output logic                                       valid_out,
    input  logic                                       ready_in,
    output vcore_i2_i3_ppln_t                          data_out
);

    generate
        if (RD_LAT != 1) begin : g_bad_rd_lat
            $error("vcore_disp_opnd_fetch: RD_LAT must be 1");
        end
        if (VDP_W != VCORE_VDP_W) begin : g_bad_vdp_w
            $error("vcore_disp_opnd_fetch: VDP_W must match VCORE_VDP_W");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_CAP  = 3'd3,
        S_OUT  = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    vcore_i2_i3_ppln_t       data_q, data_d;
    logic [VRF_ADDR_W-1:0]   src0_addr_q, src0_addr_d;
    logic [VRF_ADDR_W-1:0]   src1_addr_q, src1_addr_d;
    logic                    pend_q, pend_d;
    logic                    pend_sel_q, pend_sel_d;

    logic                    accept;
    logic                    is_ls;
    logic                    rd_fire;
    state_e                  first_state;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        src0_addr_d = src0_addr_q;
        src1_addr_d = src1_addr_q;
        pend_sel_d  = pend_sel_q;

        ready_out = ~rst & ~flush &
                    ((state_q == S_IDLE) | ((state_q == S_OUT) & ready_in));
        accept    = valid_in & ready_out;
        is_ls     = (opcode_in == VCORE_OP_VFLD)  |
                    (opcode_in == VCORE_OP_VFSLD) |
                    (opcode_in == VCORE_OP_VFST);

        vrf_rd_req  = (state_q == S_RD0) | (state_q == S_RD1);
        vrf_rd_addr = (state_q == S_RD1) ? src1_addr_q : src0_addr_q;
        rd_fire     = vrf_rd_req & vrf_rd_gnt;
        valid_out   = (state_q == S_OUT);

        if (vsrc0_vld_in)      first_state = S_RD0;
        else if (vsrc1_vld_in) first_state = S_RD1;
        else                   first_state = S_OUT;

        // A flushed cycle neither arms nor consumes a pending read.
        pend_d = rd_fire & ~flush;
        if (rd_fire) pend_sel_d = (state_q == S_RD1);

        if (pend_q && !flush) begin
            if (pend_sel_q) data_d.vsrc1_data = vrf_rd_data;
            else            data_d.vsrc0_data = vrf_rd_data;
        end

        if (accept) begin
            data_d.opcode     = opcode_in;
            data_d.vlen       = vlen_in;
            data_d.rounding   = rounding_in;
            data_d.vdst0_addr = vdst0_addr_in;
            data_d.vdst1_id   = vdst1_id_in;
            data_d.vsrc0_vld  = vsrc0_vld_in;
            data_d.vsrc1_vld  = vsrc1_vld_in;
            src0_addr_d       = vsrc0_addr_in;
            src1_addr_d       = vsrc1_addr_in;
            if (is_ls) begin
                data_d.vls_comm_ctrl_info =
                    vcore_vls_comm_ctrl_info_t'(vls_info_in);
            end
        end

        unique case (state_q)
            S_IDLE: if (accept) state_d = first_state;
            S_RD0: begin
                if (vrf_rd_gnt) state_d = data_q.vsrc1_vld ? S_RD1 : S_CAP;
            end
            S_RD1:  if (vrf_rd_gnt) state_d = S_CAP;
            S_CAP:  state_d = S_OUT;
            S_OUT: begin
                if (ready_in) state_d = accept ? first_state : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            src0_addr_q <= '0;
            src1_addr_q <= '0;
            pend_q      <= 1'b0;
            pend_sel_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            src0_addr_q <= src0_addr_d;
            src1_addr_q <= src1_addr_d;
            pend_q      <= pend_d;
            pend_sel_q  <= pend_sel_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: tb/tb_vcore_disp_opnd_fetch.sv
// Directed bench for vcore_disp_opnd_fetch with a one-cycle VRF model.

module tb_vcore_disp_opnd_fetch;
    import vcore_pkg::*;

    localparam int VLSW = $bits(vcore_vls_comm_ctrl_info_t);
    localparam logic [63:0] D_A5   = {8{8'hA5}};
    localparam logic [63:0] D_5A   = {8{8'h5A}};
    localparam logic [63:0] D_09   = {8{8'h09}};
    localparam logic [63:0] D_JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

    logic                        clk = 1'b0;
    logic                        rst, flush, valid_in, ready_out;
    logic [VCORE_OPCODE_W-1:0]   opcode_in;
    logic [VCORE_CSR_VLEN_W-1:0] vlen_in;
    logic [2:0]                  rounding_in;
    logic [4:0]                  vdst0_addr_in;
    logic [VCORE_VRF_ID_W-1:0]   vdst1_id_in;
    logic                        vsrc0_vld_in, vsrc1_vld_in;
    logic [4:0]                  vsrc0_addr_in, vsrc1_addr_in;
    logic [VLSW-1:0]             vls_info_in;
    logic                        vrf_rd_req;
    logic [4:0]                  vrf_rd_addr;
    logic                        vrf_rd_gnt;
    logic [63:0]                 vrf_rd_data = 64'h0;
    logic                        valid_out, ready_in;
    vcore_i2_i3_ppln_t           data_out;

    int checks = 0;
    int errors = 0;
    logic       req_log  [1:16];
    logic [4:0] addr_log [1:16];

    vcore_disp_opnd_fetch dut (
        .clk(clk), .rst(rst), .flush(flush),
        .valid_in(valid_in), .ready_out(ready_out),
        .opcode_in(opcode_in), .vlen_in(vlen_in),
        .rounding_in(rounding_in), .vdst0_addr_in(vdst0_addr_in),
        .vdst1_id_in(vdst1_id_in),
        .vsrc0_vld_in(vsrc0_vld_in), .vsrc1_vld_in(vsrc1_vld_in),
        .vsrc0_addr_in(vsrc0_addr_in), .vsrc1_addr_in(vsrc1_addr_in),
        .vls_info_in(vls_info_in),
        .vrf_rd_req(vrf_rd_req), .vrf_rd_addr(vrf_rd_addr),
        .vrf_rd_gnt(vrf_rd_gnt), .vrf_rd_data(vrf_rd_data),
        .valid_out(valid_out), .ready_in(ready_in), .data_out(data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] vrf_val(input logic [4:0] a);
        case (a)
            5'd3:    return D_A5;
            5'd7:    return D_5A;
            default: return {8{3'b000, a}};
        endcase
    endfunction

    // Data appears only in the cycle after a granted read; junk otherwise.
    always @(posedge clk)
        vrf_rd_data <= (vrf_rd_req && vrf_rd_gnt) ? vrf_val(vrf_rd_addr) : D_JUNK;

    task automatic set_instr(input logic [6:0] op, input logic [7:0] vl,
                             input logic s0v, input logic s1v,
                             input logic [4:0] a0, input logic [4:0] a1,
                             input logic [VLSW-1:0] vls);
        opcode_in = op; vlen_in = vl; rounding_in = 3'd2;
        vdst0_addr_in = 5'd11; vdst1_id_in = 2'd1;
        vsrc0_vld_in = s0v; vsrc1_vld_in = s1v;
        vsrc0_addr_in = a0; vsrc1_addr_in = a1; vls_info_in = vls;
    endtask

    // Accept edge, then cycles 1..max; grant held low for the first `stall` cycles.
    task automatic run_to_valid(input int max, input int stall, output int lat);
        lat = -1;
        @(posedge clk);
        for (int n = 1; n <= max; n++) begin
            @(negedge clk);
            valid_in   = 1'b0;
            vrf_rd_gnt = (n > stall);
            #1;
            req_log[n]  = vrf_rd_req;
            addr_log[n] = vrf_rd_addr;
            if (valid_out) begin
                lat = n;
                break;
            end
        end
        vrf_rd_gnt = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1; vrf_rd_gnt = 1'b1;
        set_instr(7'h0, 8'h0, 1'b0, 1'b0, 5'd0, 5'd0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (ready_out !== 1'b0) begin
            errors++; $display("FAIL reset_ready_in_rst: got %b exp 0", ready_out);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b exp 0", valid_out);
        end
        checks++;
        if (vrf_rd_req !== 1'b0) begin
            errors++; $display("FAIL reset_req: got %b exp 0", vrf_rd_req);
        end
        checks++;
        if (ready_out !== 1'b1) begin
            errors++; $display("FAIL reset_ready_after: got %b exp 1", ready_out);
        end
        checks++;
        if (data_out !== '0) begin
            errors++; $display("FAIL reset_data: got %h exp 0", data_out);
        end
    endtask

    task automatic test_two_src;
        int lat;
        @(negedge clk);
        set_instr(7'h05, 8'd32, 1'b1, 1'b1, 5'd3, 5'd7, 9'h1AB);
        valid_in = 1'b1;
        run_to_valid(16, 0, lat);
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL two_src_latency: got %0d exp 4", lat);
        end
        checks++;
        if (req_log[1] !== 1'b1 || addr_log[1] !== 5'd3 ||
            req_log[2] !== 1'b1 || addr_log[2] !== 5'd7 || req_log[3] !== 1'b0) begin
            errors++;
            $display("FAIL two_src_req_seq: got %b/%0d %b/%0d %b exp 1/3 1/7 0",
                     req_log[1], addr_log[1], req_log[2], addr_log[2], req_log[3]);
        end
        checks++;
        if (data_out.vsrc0_data !== D_A5) begin
            errors++; $display("FAIL two_src_d0: got %h exp %h", data_out.vsrc0_data, D_A5);
        end
        checks++;
        if (data_out.vsrc1_data !== D_5A) begin
            errors++; $display("FAIL two_src_d1: got %h exp %h", data_out.vsrc1_data, D_5A);
        end
        checks++;
        if (data_out.opcode !== 7'h05 || data_out.vlen !== 8'd32 ||
            data_out.rounding !== 3'd2 || data_out.vdst0_addr !== 5'd11 ||
            data_out.vdst1_id !== 2'd1 || data_out.vsrc0_vld !== 1'b1 ||
            data_out.vsrc1_vld !== 1'b1) begin
            errors++; $display("FAIL two_src_ctrl: got %h", data_out);
        end
        checks++;
        if (data_out.vls_comm_ctrl_info !== 9'h000) begin
            errors++; $display("FAIL two_src_vls_hold: got %h exp 000",
                               data_out.vls_comm_ctrl_info);
        end
        @(negedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL two_src_drain: got %b exp 0", valid_out);
        end
    endtask

    task automatic test_grant_stall;
        int lat;
        int held;
        @(negedge clk);
        set_instr(7'h06, 8'd16, 1'b1, 1'b0, 5'd9, 5'd12, '0);
        valid_in = 1'b1;
        run_to_valid(16, 3, lat);
        checks++;
        if (lat !== 6) begin
            errors++; $display("FAIL stall_latency: got %0d exp 6", lat);
        end
        held = 0;
        for (int n = 1; n <= 4; n++)
            if (req_log[n] === 1'b1 && addr_log[n] === 5'd9) held++;
        checks++;
        if (held !== 4 || req_log[5] !== 1'b0) begin
            errors++; $display("FAIL stall_req_hold: got %0d cycles req5=%b exp 4 req5=0",
                               held, req_log[5]);
        end
        checks++;
        if (data_out.vsrc0_data !== D_09) begin
            errors++; $display("FAIL stall_d0: got %h exp %h", data_out.vsrc0_data, D_09);
        end
        checks++;
        if (data_out.vsrc1_data !== D_5A) begin
            errors++; $display("FAIL stall_d1_hold: got %h exp %h", data_out.vsrc1_data, D_5A);
        end
    endtask

    task automatic test_back_to_back;
        vcore_i2_i3_ppln_t snap;
        @(negedge clk);
        set_instr(7'h07, 8'd4, 1'b0, 1'b0, 5'd1, 5'd2, '0);
        valid_in = 1'b1;
        ready_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        set_instr(7'h08, 8'd5, 1'b0, 1'b0, 5'd1, 5'd2, '0);
        #1;
        snap = data_out;
        checks++;
        if (valid_out !== 1'b1 || snap.opcode !== 7'h07 || snap.vsrc0_data !== D_09) begin
            errors++; $display("FAIL bp_first: valid=%b op=%h d0=%h exp 1 07 %h",
                               valid_out, snap.opcode, snap.vsrc0_data, D_09);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (valid_out !== 1'b1 || ready_out !== 1'b0 || data_out !== snap) begin
                errors++; $display("FAIL bp_hold%0d: valid=%b ready=%b op=%h exp 1 0 07",
                                   i, valid_out, ready_out, data_out.opcode);
            end
            @(negedge clk);
            #1;
        end
        ready_in = 1'b1;
        #1;
        checks++;
        if (ready_out !== 1'b1) begin
            errors++; $display("FAIL bp_ready_release: got %b exp 1", ready_out);
        end
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b1 || data_out.opcode !== 7'h08 || data_out.vlen !== 8'd5) begin
            errors++; $display("FAIL b2b_second: valid=%b op=%h vlen=%0d exp 1 08 5",
                               valid_out, data_out.opcode, data_out.vlen);
        end
        @(negedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL b2b_drain: got %b exp 0", valid_out);
        end
    endtask

    task automatic test_vls;
        int lat;
        @(negedge clk);
        set_instr(VCORE_OP_VFLD, 8'd8, 1'b0, 1'b0, 5'd0, 5'd0, 9'h15A);
        valid_in = 1'b1;
        run_to_valid(8, 0, lat);
        checks++;
        if (lat !== 1 || data_out.vls_comm_ctrl_info !== 9'h15A) begin
            errors++; $display("FAIL vls_latch: lat=%0d vls=%h exp 1 15a",
                               lat, data_out.vls_comm_ctrl_info);
        end
        @(negedge clk);
        set_instr(7'h05, 8'd8, 1'b0, 1'b0, 5'd0, 5'd0, 9'h0A5);
        valid_in = 1'b1;
        run_to_valid(8, 0, lat);
        checks++;
        if (data_out.opcode !== 7'h05 || data_out.vls_comm_ctrl_info !== 9'h15A) begin
            errors++; $display("FAIL vls_hold: op=%h vls=%h exp 05 15a",
                               data_out.opcode, data_out.vls_comm_ctrl_info);
        end
        @(negedge clk);
        set_instr(VCORE_OP_VFSLD, 8'd8, 1'b0, 1'b0, 5'd0, 5'd0, 9'h033);
        valid_in = 1'b1;
        run_to_valid(8, 0, lat);
        checks++;
        if (data_out.vls_comm_ctrl_info !== 9'h033) begin
            errors++; $display("FAIL vls_vfsld: got %h exp 033", data_out.vls_comm_ctrl_info);
        end
    endtask

    task automatic test_flush;
        int lat;
        int bad;
        @(negedge clk);
        set_instr(7'h05, 8'd8, 1'b1, 1'b1, 5'd7, 5'd9, '0);
        valid_in = 1'b1;
        vrf_rd_gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        #1;
        checks++;
        if (vrf_rd_req !== 1'b1 || vrf_rd_addr !== 5'd7) begin
            errors++; $display("FAIL flush_rd0: req=%b addr=%0d exp 1 7", vrf_rd_req, vrf_rd_addr);
        end
        @(negedge clk);
        flush = 1'b1;
        #1;
        checks++;
        if (ready_out !== 1'b0 || vrf_rd_addr !== 5'd9) begin
            errors++; $display("FAIL flush_in_rd1: ready=%b addr=%0d exp 0 9", ready_out, vrf_rd_addr);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || vrf_rd_req !== 1'b0 || ready_out !== 1'b1) begin
            errors++; $display("FAIL flush_idle: valid=%b req=%b ready=%b exp 0 0 1",
                               valid_out, vrf_rd_req, ready_out);
        end
        checks++;
        if (data_out.vsrc0_data !== D_09) begin
            errors++; $display("FAIL flush_d0_kept: got %h exp %h", data_out.vsrc0_data, D_09);
        end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (valid_out !== 1'b0 || data_out.vsrc0_data !== D_09) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL flush_quiet: got %0d bad cycles exp 0", bad);
        end
        @(negedge clk);
        set_instr(7'h05, 8'd8, 1'b1, 1'b1, 5'd3, 5'd9, '0);
        valid_in = 1'b1;
        run_to_valid(16, 0, lat);
        checks++;
        if (lat !== 4 || data_out.vsrc0_data !== D_A5 || data_out.vsrc1_data !== D_09) begin
            errors++; $display("FAIL flush_recover: lat=%0d d0=%h d1=%h exp 4 %h %h",
                               lat, data_out.vsrc0_data, data_out.vsrc1_data, D_A5, D_09);
        end
    endtask

    initial begin
        test_reset();
        test_two_src();
        test_grant_stall();
        test_back_to_back();
        test_vls();
        test_flush();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vcore_disp_opnd_fetch.md
Name: vcore_disp_opnd_fetch

Overview:
- Vector dispatch operand-fetch stage, directly upstream of the dispatch-to-execute pipeline register.
- Accepts one decoded vector instruction from dispatch and sequences up to two reads of the VRF through a single shared, arbitrated read port.
- Assembles a complete vcore_i2_i3_ppln_t payload, then presents it downstream with a valid/ready handshake.
- Holds one instruction at a time; back-to-back issue is supported on the downstream handshake cycle.

Parameters:
- VDP_W, VCORE_VDP_W: vector source data width.
- VRF_ADDR_W, 5: VRF read address width.
- RD_LAT, 1: VRF read data latency in cycles. Fixed at 1; any other value is a compile-time error.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of the held instruction.
- valid_in  in  1  dispatch instruction valid.
- ready_out  out  1  stage can accept.
- opcode_in  in  VCORE_OPCODE_W  opcode.
- vlen_in  in  VCORE_CSR_VLEN_W  vector length.
- rounding_in  in  3  rounding mode.
- vdst0_addr_in  in  5  destination 0 address.
- vdst1_id_in  in  VCORE_VRF_ID_W  destination 1 id.
- vsrc0_vld_in / vsrc1_vld_in  in  1 each  source needs a VRF read.
- vsrc0_addr_in / vsrc1_addr_in  in  VRF_ADDR_W each  source addresses.
- vls_info_in  in  $bits(vcore_vls_comm_ctrl_info_t)  load/store control info.
- vrf_rd_req  out  1  VRF read request.
- vrf_rd_addr  out  VRF_ADDR_W  read address.
- vrf_rd_gnt  in  1  arbiter grant; the read occurs in a cycle where req & gnt.
- vrf_rd_data  in  VDP_W  read data, valid exactly 1 cycle after a granted read.
- valid_out  out  1  payload valid.
- ready_in  in  1  downstream ready.
- data_out  out  vcore_i2_i3_ppln_t  registered payload.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset state:
  - FSM goes to IDLE; valid_out=0, vrf_rd_req=0.
  - All data_out fields are 0.
  - ready_out=0 while rst is high.
- FSM states: IDLE, RD0, RD1, CAP, OUT.
- ready_out = ~rst & ~flush & (IDLE | (OUT & ready_in)).
- Accept: accept = valid_in & ready_out. On accept:
  - opcode, vlen, rounding, vdst0_addr, vdst1_id, vsrc0_vld and vsrc1_vld are latched into data_out.
  - Source addresses are latched internally.
  - vls_comm_ctrl_info is latched only if the opcode is VFLD, VFSLD or VFST; otherwise it holds its value.
  - Next state: RD0 if vsrc0_vld; else RD1 if vsrc1_vld; else OUT.
- RD0:
  - vrf_rd_req=1, vrf_rd_addr=src0 address.
  - On gnt: next state RD1 if vsrc1_vld, else CAP. Without gnt: stay in RD0.
- RD1:
  - vrf_rd_req=1, vrf_rd_addr=src1 address.
  - On gnt: next state CAP. Without gnt: stay in RD1.
- Read capture:
  - A one-bit pending flag and a source-select bit are registered on each granted read.
  - In the following cycle, vrf_rd_data is written into data_out.vsrc0_data or data_out.vsrc1_data accordingly, regardless of the current state.
  - vsrcN_data is not written when vsrcN_vld=0; it holds its value.
- CAP: captures the final read data; next state is OUT. No request is made.
- OUT:
  - valid_out=1 and data_out is stable until ready_in.
  - On ready_in: if a new accept occurs in the same cycle, that instruction starts as from IDLE; otherwise next state is IDLE.
- Latency, accept edge to first valid_out cycle, with no grant stalls:
  - no sources: 1 cycle;
  - one source: 3 cycles;
  - two sources: 4 cycles.
  - Each cycle of grant denial adds one cycle.
- vrf_rd_req is asserted only in RD0/RD1, and vrf_rd_addr is held stable while ungranted.
- flush:
  - Next state is IDLE from any state.
  - The pending read data is discarded (the pending flag is cleared) and valid_out is 0 next cycle.
  - flush has priority over accept and over the downstream handshake.
  - data_out fields are not cleared.
- rst mid-operation behaves as flush and additionally zeroes data_out.
- valid_out never drops without ready_in, except on flush or rst.

Test Plan:
- Reset: hold rst 2 cycles, release -> valid_out=0, vrf_rd_req=0, ready_out=1 in the first cycle after release, all data_out fields 0.
- Two sources: opcode non-LS, vsrc0_addr=3, vsrc1_addr=7, gnt tied 1, VRF model returns 0xA5.. at addr 3 and 0x5A.. at addr 7 -> req addr 3 then 7 on consecutive cycles, valid_out 4 cycles after accept, vsrc0_data=0xA5.., vsrc1_data=0x5A...
- Grant stall: single source, addr 9, gnt low 3 cycles -> req held with addr 9 for 4 cycles, valid_out 6 cycles after accept, correct data captured.
- No sources plus backpressure: ready_in low 5 cycles -> valid_out held 5+ cycles with data_out stable, ready_out=0 throughout; a second instruction is accepted in the ready_in cycle and appears back-to-back.
- Opcode VFLD with vls_info=X, then non-LS opcode with vls_info=Y -> data_out.vls_comm_ctrl_info remains X.
- Flush in RD1 with a pending src0 read -> IDLE next cycle, valid_out stays 0, vsrc0_data unchanged from its prior value, next instruction completes normally.
